bcd_conv: RTL and testbench

BCD_CONV -- requirements
Module: bcd_conv

---
 rtl/bcd_conv.sv | 104 ++++++++++
 tb/tb_bcd_conv.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/bcd_conv.sv
// Sequential 8-bit binary to 3-digit BCD converter (double dabble) with
// 7-segment decode of each registered digit.
module bcd_conv (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init,
  input  logic [7:0]  pp,
  output logic [11:0] bcd,
  output logic [6:0]  seg_h,
  output logic [6:0]  seg_t,
  output logic [6:0]  seg_u,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, ADJ, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [19:0] scratch, scratch_nxt;
  logic [2:0]  count, count_nxt;
  logic [11:0] bcd_nxt;

  // Nibble adds are confined to 4 bits; carries only move on the following shift.
  function automatic logic [3:0] adj3(input logic [3:0] nib);
    return (nib >= 4'd5) ? nib + 4'd3 : nib;
  endfunction

  function automatic logic [6:0] seg7(input logic [3:0] digit);
    logic [6:0] code;
    case (digit)
      4'd0:    code = 7'h3F;
      4'd1:    code = 7'h06;
      4'd2:    code = 7'h5B;
      4'd3:    code = 7'h4F;
      4'd4:    code = 7'h66;
      4'd5:    code = 7'h6D;
      4'd6:    code = 7'h7D;
      4'd7:    code = 7'h07;
      4'd8:    code = 7'h7F;
      4'd9:    code = 7'h6F;
      default: code = 7'h00;
    endcase
    return code;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      scratch <= '0;
      count   <= '0;
      bcd     <= '0;
    end else begin
      state   <= state_nxt;
      scratch <= scratch_nxt;
      count   <= count_nxt;
      bcd     <= bcd_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    scratch_nxt = scratch;
    count_nxt   = count;
    bcd_nxt     = bcd;
    case (state)
      IDLE: begin
        if (init) begin
          scratch_nxt = {12'b0, pp};
          count_nxt   = '0;
          state_nxt   = ADJ;
        end
      end
      ADJ: begin
        scratch_nxt = {adj3(scratch[19:16]), adj3(scratch[15:12]),
                       adj3(scratch[11:8]), scratch[7:0]};
        state_nxt   = SHIFT;
      end
      SHIFT: begin
        scratch_nxt = {scratch[18:0], 1'b0};
        count_nxt   = count + 3'd1;
        if (count == 3'd7) begin
          // Publish the post-shift digits, i.e. the upper 12 bits of the shifted value.
          bcd_nxt   = scratch[18:7];
          state_nxt = DONE;
        end else begin
          state_nxt = ADJ;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy  = (state != IDLE);
  assign done  = (state == DONE);
  assign seg_h = seg7(bcd[11:8]);
  assign seg_t = seg7(bcd[7:4]);
  assign seg_u = seg7(bcd[3:0]);

endmodule

// File: tb/tb_bcd_conv.sv
// Directed bench for bcd_conv: a table of conversions with exact latency
// checks, plus sequences for mid-run pp/init changes, held init and abort by reset.
module tb_bcd_conv;

  logic        clk;
  logic        rst_n;
  logic        init;
  logic [7:0]  pp;
  logic [11:0] bcd;
  logic [6:0]  seg_h, seg_t, seg_u;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;
  int edge_idx = 0;

  typedef struct {
    logic [7:0]  pp;
    logic [11:0] bcd;
    logic [6:0]  seg_h;
    logic [6:0]  seg_t;
    logic [6:0]  seg_u;
  } vec_t;

  vec_t vecs [14];

  bcd_conv dut (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .pp    (pp),
    .bcd   (bcd),
    .seg_h (seg_h),
    .seg_t (seg_t),
    .seg_u (seg_u),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) edge_idx <= edge_idx + 1;

  task automatic check_output(input string name, input logic [11:0] actual,
                              input logic [11:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s got %h want %h", name, actual, expected);
    end
  endtask

  // Drives one init pulse sampled at the next rising edge (edge k), returns at the negedge after k.
  task automatic apply_stimulus(input logic [7:0] value);
    @(negedge clk);
    pp   = value;
    init = 1'b1;
    @(posedge clk);
    @(negedge clk);
    init = 1'b0;
  endtask

  initial begin
    int early;
    int pulses;
    int k;

    vecs[0]  = '{8'd0,   12'h000, 7'h3F, 7'h3F, 7'h3F};
    vecs[1]  = '{8'd225, 12'h225, 7'h5B, 7'h5B, 7'h6D};
    vecs[2]  = '{8'd255, 12'h255, 7'h5B, 7'h6D, 7'h6D};
    vecs[3]  = '{8'd1,   12'h001, 7'h3F, 7'h3F, 7'h06};
    vecs[4]  = '{8'd9,   12'h009, 7'h3F, 7'h3F, 7'h6F};
    vecs[5]  = '{8'd10,  12'h010, 7'h3F, 7'h06, 7'h3F};
    vecs[6]  = '{8'd99,  12'h099, 7'h3F, 7'h6F, 7'h6F};
    vecs[7]  = '{8'd100, 12'h100, 7'h06, 7'h3F, 7'h3F};
    vecs[8]  = '{8'd128, 12'h128, 7'h06, 7'h5B, 7'h7F};
    vecs[9]  = '{8'd199, 12'h199, 7'h06, 7'h6F, 7'h6F};
    vecs[10] = '{8'd200, 12'h200, 7'h5B, 7'h3F, 7'h3F};
    vecs[11] = '{8'd47,  12'h047, 7'h3F, 7'h66, 7'h07};
    vecs[12] = '{8'd63,  12'h063, 7'h3F, 7'h7D, 7'h4F};
    vecs[13] = '{8'd85,  12'h085, 7'h3F, 7'h7F, 7'h6D};

    rst_n = 1'b0;
    init  = 1'b0;
    pp    = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_output("reset_bcd",   bcd,           12'h000);
    check_output("reset_busy",  {11'b0, busy}, 12'h000);
    check_output("reset_done",  {11'b0, done}, 12'h000);
    check_output("reset_seg_h", {5'b0, seg_h}, 12'h03F);
    check_output("reset_seg_t", {5'b0, seg_t}, 12'h03F);
    check_output("reset_seg_u", {5'b0, seg_u}, 12'h03F);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_output("release_idle_busy", {11'b0, busy}, 12'h000);

    for (int v = 0; v < 14; v++) begin
      apply_stimulus(vecs[v].pp);
      early = 0;
      for (int e = 1; e <= 15; e++) begin
        @(negedge clk);
        if (done) early++;
      end
      check_output("done_not_early", early[11:0], 12'h000);
      @(negedge clk);
      check_output("done_at_k16", {11'b0, done}, 12'h001);
      check_output("bcd",   bcd,                 vecs[v].bcd);
      check_output("seg_h", {5'b0, seg_h},       {5'b0, vecs[v].seg_h});
      check_output("seg_t", {5'b0, seg_t},       {5'b0, vecs[v].seg_t});
      check_output("seg_u", {5'b0, seg_u},       {5'b0, vecs[v].seg_u});
      @(negedge clk);
      check_output("done_fall_k17", {11'b0, done}, 12'h000);
      check_output("idle_k17_busy", {11'b0, busy}, 12'h000);
    end

    // pp changes during conversion must not matter; busy spans edges k..k+16.
    apply_stimulus(8'd99);
    early = 0;
    for (int e = 1; e <= 16; e++) begin
      if (e == 3) pp = 8'd7;
      if (!busy) early++;
      @(negedge clk);
    end
    if (!busy) early++;
    check_output("busy_span", early[11:0], 12'h000);
    check_output("pp_change_bcd", bcd, 12'h099);
    @(negedge clk);
    check_output("busy_low_k17", {11'b0, busy}, 12'h000);

    // A second init during the conversion is ignored.
    apply_stimulus(8'd255);
    k = edge_idx - 1;
    pulses = 0;
    for (int e = 1; e <= 40; e++) begin
      if (e == 4) begin
        init = 1'b1;
        pp   = 8'd1;
      end
      if (e == 5) init = 1'b0;
      @(negedge clk);
      if (done) begin
        pulses++;
        check_output("ignored_init_done_edge", 12'(edge_idx - 1 - k), 12'd16);
      end
    end
    check_output("ignored_init_pulses", pulses[11:0], 12'd1);
    check_output("ignored_init_bcd", bcd, 12'h255);

    // Held init restarts every 18 cycles.
    @(negedge clk);
    pp   = 8'd128;
    init = 1'b1;
    @(posedge clk);
    k = edge_idx - 1;
    @(negedge clk);
    pulses = 0;
    for (int e = 1; e <= 35; e++) begin
      @(negedge clk);
      if (done) begin
        pulses++;
        if (e == 16 || e == 34) check_output("held_bcd", bcd, 12'h128);
        else check_output("held_unexpected_done_edge", 12'(edge_idx - 1 - k), 12'd0);
      end
    end
    init = 1'b0;
    check_output("held_pulses", pulses[11:0], 12'd2);

    // Reset mid-conversion aborts without done and clears bcd at once.
    repeat (3) @(negedge clk);
    apply_stimulus(8'd200);
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_output("abort_busy", {11'b0, busy}, 12'h000);
    check_output("abort_bcd",  bcd,           12'h000);
    check_output("abort_done", {11'b0, done}, 12'h000);
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    early  = 0;
    for (int e = 0; e < 25; e++) begin
      @(negedge clk);
      if (done) pulses++;
      if (busy) early++;
    end
    check_output("abort_no_done",    pulses[11:0], 12'd0);
    check_output("abort_stays_idle", early[11:0],  12'd0);
    check_output("abort_bcd_held",   bcd,          12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
